// File: rtl/snn_queue_pkg.sv
// Shared definitions for the spike event queue and the producers that feed it.
package snn_queue_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 16;

  typedef logic [DATA_W-1:0] event_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after rr_ptr.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] grant
);

  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] idx;
  logic [PW-1:0] win;
  logic          found;

  always_comb begin
    grant    = '0;
    found    = 1'b0;
    win      = '0;
    idx      = '0;
    rr_ptr_d = rr_ptr_q;
    if (en) begin
      for (int unsigned i = 0; i < N; i++) begin
        idx = PW'((32'(rr_ptr_q) + i) % N);
        if (!found && req[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
          win        = idx;
        end
      end
      if (found) begin
        rr_ptr_d = (win == PW'(N - 1)) ? '0 : win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/spike_queue_arbiter.sv
// Shares one event queue between NUM_REQ spike producers and one consumer,
// with occupancy tracking so producers are held off before overflow.
module spike_queue_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = snn_queue_pkg::DATA_W,
  parameter int unsigned DEPTH   = snn_queue_pkg::DEPTH,
  parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      q_insert_o,
  output logic [DATA_W-1:0]         q_data_o,
  output logic                      q_read_o,
  input  logic                      q_valid_i,
  input  logic [DATA_W-1:0]         q_data_i,
  input  logic                      pop_i,
  output logic                      pop_valid_o,
  output logic [DATA_W-1:0]         pop_data_o,
  output logic [CNT_W-1:0]          count_o,
  output logic                      full_o,
  output logic                      empty_o
);

  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic               pop_acc;
  logic               full, empty;
  logic [DATA_W-1:0]  win_data;

  logic [CNT_W-1:0]  count_q, count_d;
  logic              q_insert_q, q_insert_d;
  logic [DATA_W-1:0] q_data_q, q_data_d;
  logic              q_read_q, q_read_d;
  logic              rd_pend_q, rd_pend_d;
  logic              pop_valid_q, pop_valid_d;
  logic [DATA_W-1:0] pop_data_q, pop_data_d;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Holding en low during reset keeps req_ready_o at zero while rst is high.
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk   (clk),
    .rst   (rst),
    .req   (req_valid_i),
    .en    (!full && !rst),
    .grant (grant)
  );

  always_comb begin
    grant_any   = |grant;
    pop_acc     = pop_i && !empty;
    win_data    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) win_data = req_data_i[i*DATA_W +: DATA_W];
    end

    q_insert_d  = grant_any;
    q_data_d    = grant_any ? win_data : q_data_q;
    q_read_d    = pop_acc;
    // Queue output appears the cycle after its read strobe; only that cycle is trusted.
    rd_pend_d   = q_read_q;
    pop_valid_d = q_valid_i && rd_pend_q;
    pop_data_d  = pop_valid_d ? q_data_i : pop_data_q;

    unique case ({grant_any, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= '0;
      q_insert_q  <= 1'b0;
      q_data_q    <= '0;
      q_read_q    <= 1'b0;
      rd_pend_q   <= 1'b0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      q_insert_q  <= q_insert_d;
      q_data_q    <= q_data_d;
      q_read_q    <= q_read_d;
      rd_pend_q   <= rd_pend_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

  assign req_ready_o = grant;
  assign q_insert_o  = q_insert_q;
  assign q_data_o    = q_data_q;
  assign q_read_o    = q_read_q;
  assign pop_valid_o = pop_valid_q;
  assign pop_data_o  = pop_data_q;
  assign count_o     = count_q;
  assign full_o      = full;
  assign empty_o     = empty;

endmodule

// File: tb/tb_spike_queue_arbiter.sv
// Directed bench for spike_queue_arbiter with a behavioural queue on the far side.
module tb_spike_queue_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid_i;
  logic [31:0] req_data_i;
  logic [3:0]  req_ready_o;
  logic        q_insert_o;
  logic [7:0]  q_data_o;
  logic        q_read_o;
  logic        q_valid_i;
  logic [7:0]  q_data_i;
  logic        pop_i;
  logic        pop_valid_o;
  logic [7:0]  pop_data_o;
  logic [4:0]  count_o;
  logic        full_o;
  logic        empty_o;

  int ncmp = 0;
  int nfail = 0;

  spike_queue_arbiter #(.NUM_REQ(4), .DATA_W(8), .DEPTH(16), .CNT_W(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .q_insert_o  (q_insert_o),
    .q_data_o    (q_data_o),
    .q_read_o    (q_read_o),
    .q_valid_i   (q_valid_i),
    .q_data_i    (q_data_i),
    .pop_i       (pop_i),
    .pop_valid_o (pop_valid_o),
    .pop_data_o  (pop_data_o),
    .count_o     (count_o),
    .full_o      (full_o),
    .empty_o     (empty_o)
  );

  always #5 clk = ~clk;

  // Behavioural queue: registered read data one cycle after the read strobe.
  logic [7:0] mem[$];
  always @(posedge clk) begin
    if (rst) begin
      mem.delete();
      q_valid_i <= 1'b0;
      q_data_i  <= '0;
    end else begin
      if (q_read_o && mem.size() > 0) begin
        q_valid_i <= 1'b1;
        q_data_i  <= mem[0];
        mem.pop_front();
      end else begin
        q_valid_i <= 1'b0;
      end
      if (q_insert_o) mem.push_back(q_data_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid_i = '0; pop_i = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pop_i = 1'b0;
    req_valid_i = 4'hF; req_data_i = 32'h13121110;
    #1;
    ncmp++; if (req_ready_o !== 4'b0000) begin nfail++; $display("FAIL reset_ready got %b exp 0000", req_ready_o); end
    tick(); tick();
    ncmp++; if (req_ready_o !== 4'b0000) begin nfail++; $display("FAIL reset_ready2 got %b exp 0000", req_ready_o); end
    ncmp++; if (count_o !== 5'd0) begin nfail++; $display("FAIL reset_count got %0d exp 0", count_o); end
    ncmp++; if (empty_o !== 1'b1 || full_o !== 1'b0) begin nfail++; $display("FAIL reset_flags got e%b f%b exp e1 f0", empty_o, full_o); end
    ncmp++; if (q_insert_o !== 1'b0 || q_read_o !== 1'b0) begin nfail++; $display("FAIL reset_strobes got ins%b rd%b exp 0 0", q_insert_o, q_read_o); end
    ncmp++; if (q_data_o !== 8'h00 || pop_valid_o !== 1'b0 || pop_data_o !== 8'h00) begin nfail++; $display("FAIL reset_data got qd%h pv%b pd%h exp 00 0 00", q_data_o, pop_valid_o, pop_data_o); end
    rst = 1'b0; req_valid_i = '0;
  endtask

  task automatic test_fairness();
    logic [3:0] exp_g;
    logic [7:0] exp_d;
    req_data_i = 32'h13121110; req_valid_i = 4'hF;
    for (int k = 0; k < 8; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_d = 8'h10 + 8'(k % 4);
      #1;
      ncmp++; if (req_ready_o !== exp_g) begin nfail++; $display("FAIL fair_grant[%0d] got %b exp %b", k, req_ready_o, exp_g); end
      tick();
      ncmp++; if (q_insert_o !== 1'b1 || q_data_o !== exp_d) begin nfail++; $display("FAIL fair_qdata[%0d] got ins%b %h exp ins1 %h", k, q_insert_o, q_data_o, exp_d); end
    end
    req_valid_i = '0;
    tick();
    ncmp++; if (count_o !== 5'd8 || q_insert_o !== 1'b0) begin nfail++; $display("FAIL fair_count got %0d ins%b exp 8 ins0", count_o, q_insert_o); end
  endtask

  task automatic test_full();
    req_data_i = 32'h00220000; req_valid_i = 4'b0100;
    for (int k = 0; k < 16; k++) begin
      #1;
      ncmp++; if (req_ready_o !== 4'b0100) begin nfail++; $display("FAIL full_fill[%0d] got %b exp 0100", k, req_ready_o); end
      tick();
    end
    ncmp++; if (count_o !== 5'd16 || full_o !== 1'b1) begin nfail++; $display("FAIL full_flag got cnt%0d f%b exp 16 1", count_o, full_o); end
    ncmp++; if (req_ready_o !== 4'b0000) begin nfail++; $display("FAIL full_ready got %b exp 0000", req_ready_o); end
    tick();
    ncmp++; if (q_insert_o !== 1'b0 || count_o !== 5'd16) begin nfail++; $display("FAIL full_hold got ins%b cnt%0d exp 0 16", q_insert_o, count_o); end
    pop_i = 1'b1;
    #1;
    ncmp++; if (req_ready_o !== 4'b0000) begin nfail++; $display("FAIL full_pop_ready got %b exp 0000", req_ready_o); end
    tick();
    pop_i = 1'b0;
    ncmp++; if (count_o !== 5'd15 || q_read_o !== 1'b1 || q_insert_o !== 1'b0) begin nfail++; $display("FAIL full_pop got cnt%0d rd%b ins%b exp 15 1 0", count_o, q_read_o, q_insert_o); end
    #1;
    ncmp++; if (req_ready_o !== 4'b0100) begin nfail++; $display("FAIL full_regrant got %b exp 0100", req_ready_o); end
    tick();
    req_valid_i = '0;
    ncmp++; if (count_o !== 5'd16 || q_insert_o !== 1'b1) begin nfail++; $display("FAIL full_refill got cnt%0d ins%b exp 16 1", count_o, q_insert_o); end
    tick();
    ncmp++; if (pop_valid_o !== 1'b1 || pop_data_o !== 8'h22) begin nfail++; $display("FAIL full_popdata got v%b %h exp 1 22", pop_valid_o, pop_data_o); end
  endtask

  task automatic test_pop_data();
    req_valid_i = 4'b0001;
    req_data_i = 32'h00000001; tick();
    req_data_i = 32'h00000002; tick();
    req_data_i = 32'h00000003; tick();
    req_valid_i = '0;
    ncmp++; if (count_o !== 5'd3) begin nfail++; $display("FAIL pop_fill got %0d exp 3", count_o); end
    pop_i = 1'b1;
    tick();
    ncmp++; if (q_read_o !== 1'b1 || pop_valid_o !== 1'b0) begin nfail++; $display("FAIL pop_strobe got rd%b pv%b exp 1 0", q_read_o, pop_valid_o); end
    tick();
    ncmp++; if (pop_valid_o !== 1'b0) begin nfail++; $display("FAIL pop_early got %b exp 0", pop_valid_o); end
    tick();
    pop_i = 1'b0;
    ncmp++; if (pop_valid_o !== 1'b1 || pop_data_o !== 8'h01) begin nfail++; $display("FAIL pop_d1 got v%b %h exp 1 01", pop_valid_o, pop_data_o); end
    ncmp++; if (count_o !== 5'd0 || empty_o !== 1'b1) begin nfail++; $display("FAIL pop_count got %0d e%b exp 0 1", count_o, empty_o); end
    tick();
    ncmp++; if (pop_valid_o !== 1'b1 || pop_data_o !== 8'h02) begin nfail++; $display("FAIL pop_d2 got v%b %h exp 1 02", pop_valid_o, pop_data_o); end
    tick();
    ncmp++; if (pop_valid_o !== 1'b1 || pop_data_o !== 8'h03) begin nfail++; $display("FAIL pop_d3 got v%b %h exp 1 03", pop_valid_o, pop_data_o); end
    tick();
    ncmp++; if (pop_valid_o !== 1'b0) begin nfail++; $display("FAIL pop_end got %b exp 0", pop_valid_o); end
  endtask

  task automatic test_empty_pop();
    pop_i = 1'b1;
    tick();
    pop_i = 1'b0;
    ncmp++; if (q_read_o !== 1'b0 || count_o !== 5'd0) begin nfail++; $display("FAIL empty_pop got rd%b cnt%0d exp 0 0", q_read_o, count_o); end
    tick(); tick();
    ncmp++; if (pop_valid_o !== 1'b0 || empty_o !== 1'b1) begin nfail++; $display("FAIL empty_ret got pv%b e%b exp 0 1", pop_valid_o, empty_o); end
  endtask

  task automatic test_simultaneous();
    req_valid_i = 4'b0001; req_data_i = 32'h00000055;
    for (int k = 0; k < 5; k++) tick();
    ncmp++; if (count_o !== 5'd5) begin nfail++; $display("FAIL simul_fill got %0d exp 5", count_o); end
    pop_i = 1'b1;
    #1;
    ncmp++; if (req_ready_o !== 4'b0001) begin nfail++; $display("FAIL simul_ready got %b exp 0001", req_ready_o); end
    tick();
    ncmp++; if (count_o !== 5'd5 || q_read_o !== 1'b1 || q_insert_o !== 1'b1) begin nfail++; $display("FAIL simul_count got %0d rd%b ins%b exp 5 1 1", count_o, q_read_o, q_insert_o); end
    req_valid_i = 4'hF; rst = 1'b1;
    #1;
    ncmp++; if (req_ready_o !== 4'b0000) begin nfail++; $display("FAIL midrst_ready got %b exp 0000", req_ready_o); end
    tick();
    ncmp++; if (q_insert_o !== 1'b0 || q_read_o !== 1'b0 || q_data_o !== 8'h00) begin nfail++; $display("FAIL midrst_q got ins%b rd%b %h exp 0 0 00", q_insert_o, q_read_o, q_data_o); end
    ncmp++; if (count_o !== 5'd0 || empty_o !== 1'b1 || full_o !== 1'b0) begin nfail++; $display("FAIL midrst_cnt got %0d e%b f%b exp 0 1 0", count_o, empty_o, full_o); end
    rst = 1'b0; req_valid_i = '0; pop_i = 1'b0;
    tick(); tick();
    ncmp++; if (pop_valid_o !== 1'b0 || pop_data_o !== 8'h00) begin nfail++; $display("FAIL midrst_pop got v%b %h exp 0 00", pop_valid_o, pop_data_o); end
  endtask

  initial begin
    rst = 1'b1; req_valid_i = '0; req_data_i = '0; pop_i = 1'b0;
    test_reset();
    do_reset();
    test_fairness();
    do_reset();
    test_full();
    do_reset();
    test_pop_data();
    test_empty_pop();
    test_simultaneous();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/spike_queue_arbiter.md
# spike_queue_arbiter

Shares one `queue` instance (8-bit spike/event FIFO) between `NUM_REQ` producers and one consumer. Producers get round-robin grants, and the block tracks queue occupancy so producers are back-pressured before overflow. It also sequences consumer pops into `queue` `read` strobes and returns the data. It sits between the neuron-layer spike sources and the shared event queue.

## Interface
Parameters:
- `NUM_REQ`, 4, number of producer ports (≥2)
- `DATA_W`, 8, event width; matches `queue` data width
- `DEPTH`, 16, queue capacity in entries
- `CNT_W`, $clog2(DEPTH+1), occupancy counter width

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req_valid_i`  in  NUM_REQ  producer i has an event
- `req_data_i`  in  NUM_REQ*DATA_W  producer i event; slice i = bits [i*DATA_W +: DATA_W]
- `req_ready_o`  out  NUM_REQ  one-hot grant; handshake completes at the edge where valid&ready
- `q_insert_o`  out  1  to `queue.insert`
- `q_data_o`  out  DATA_W  to `queue.data_i`
- `q_read_o`  out  1  to `queue.read`
- `q_valid_i`  in  1  from `queue.valid_o`
- `q_data_i`  in  DATA_W  from `queue.data_o`
- `pop_i`  in  1  consumer requests one event
- `pop_valid_o`  out  1  returned event valid, single-cycle pulse
- `pop_data_o`  out  DATA_W  returned event
- `count_o`  out  CNT_W  entries committed (inserted or in flight to insert, minus popped)
- `full_o` / `empty_o`  out  1  count_o == DEPTH / count_o == 0

## Operation
- Arbitration:
  - Eligible set = `req_valid_i` when `!full_o`; empty set when full.
  - Round-robin winner = first eligible index at or after `rr_ptr`, wrapping.
  - `req_ready_o` is combinational and one-hot, and is zero when nothing is eligible.
  - On a grant, `rr_ptr` ← winner+1 mod NUM_REQ. Otherwise `rr_ptr` is held.
- Insert path: a grant at edge t registers `q_insert_o`=1 and `q_data_o`=winner data for cycle t+1. With no grant, `q_insert_o`=0 and `q_data_o` holds its last value.
- Pop path:
  - `pop_i` is accepted only when `!empty_o`. An accepted pop registers `q_read_o`=1 for the next cycle.
  - `pop_i` while empty is ignored, with no read strobe and no count change.
  - `pop_valid_o`/`pop_data_o` are registered copies of `q_valid_i`/`q_data_i`, gated by a read-pending shift bit. `q_valid_i` outside a pending read is ignored.
- Counter:
  - +1 on a grant, −1 on an accepted pop, unchanged when both occur in the same cycle.
  - Never exceeds DEPTH or goes below 0; the eligibility and accept rules guarantee this.
- Full with a same-cycle pop: no grant is given that cycle. The freed slot becomes grantable the next cycle.
- Requester valid dropping without ready: allowed; no state change.

## Timing
- Reset values:
  - `req_ready_o`=0 while `rst`=1.
  - `q_insert_o`=0, `q_read_o`=0, `q_data_o`=0.
  - `pop_valid_o`=0, `pop_data_o`=0.
  - `count_o`=0, so `empty_o`=1 and `full_o`=0.
  - `rr_ptr`=0, read-pending=0.
- Insert latency: grant edge t → `q_insert_o` high in cycle t+1 → entry written at edge t+1.
- Pop latency: `pop_i` accepted at edge t → `q_read_o` high in cycle t+1 → `queue` `valid_o` in cycle t+2 → `pop_valid_o` in cycle t+3.
- Sustained throughput: one insert and one pop per cycle.
- Reset mid-operation:
  - In-flight insert and read strobes are dropped, the count clears, and pending returns are discarded.
  - `queue` shares `rst`, so both sides stay consistent.

## Structure
- Shared package `snn_queue_pkg`: `DATA_W`, `DEPTH`, and a `event_t` typedef of `logic [DATA_W-1:0]`. Reused by `queue` and the spike sources.
- Sub-module `rr_arbiter`, parameterised by N:
  - Inputs: `req`, `en`.
  - Outputs: one-hot `grant`.
  - Owns the internal `rr_ptr`.
- The top level holds the counter, the insert/read registers and the read-pending pipeline.

## Test plan
- Reset: hold `rst` 2 cycles with all producers valid → `req_ready_o`=0, `count_o`=0, `empty_o`=1, no `q_insert_o`.
- Fairness:
  - Stimulus: producers 0–3 valid with data 8'h10–8'h13 for 8 cycles.
  - Response: grants 0,1,2,3,0,1,2,3; `q_data_o` sequence 10,11,12,13,10,…, each one cycle after its grant.
- Full:
  - Stimulus: producer 2 alone, continuously valid.
  - Response: 16 grants, then `full_o`=1 and `req_ready_o`=0.
  - Stimulus: one `pop_i` while full.
  - Response: no grant that cycle; one grant the next cycle; `count_o` returns to 16.
- Pop data:
  - Stimulus: insert 8'h01, 8'h02, 8'h03 from producer 0, then pop three consecutive cycles.
  - Response: `pop_valid_o` pulses 3 cycles after each pop with 01, 02, 03; `count_o` ends at 0.
- Empty pop: `pop_i` with `count_o`=0 → no `q_read_o`, no `pop_valid_o`, `count_o` stays 0.
- Simultaneous: with `count_o`=5, one grant plus one accepted pop in the same cycle → `count_o` stays 5. Assert `rst` mid-stream → all outputs return to reset values next cycle.
